// File: rtl/reconf_ctrl.sv
// -----------------------------------------------------------------------------
// reconf_ctrl
//   Sequences run-time reconfiguration of the multi-dataflow accelerator kernel.
//   A request is accepted only while running. An illegal ID is dropped with an
//   err_id pulse. A request for the ID already in use completes at once with
//   done. Any other ID closes the input, waits for the datapath to drain,
//   switches cfg_id, waits a settle time, then re-opens the input with done.
//
//   Optional feature macro: RECONF_DRAIN_TIMEOUT_EN
//     When this macro is defined, the block adds the err_timeout output. If DRAIN
//     lasts TIMEOUT_CYCLES cycles, the reconfiguration is aborted. The old cfg_id
//     is kept and err_timeout pulses.
//
// Ports
//   clock, reset        single rising-edge clock, async active-high reset
//   req_valid/req_id    reconfiguration request (network ID)
//   req_ready           high only while running
//   dp_in_valid/ready   datapath input handshake (valid already gated by in_en)
//   dp_out_valid/ready  datapath output handshake
//   in_en               registered input enable, ANDed into the input handshake
//   cfg_id              registered ID driven into the ID-to-sel configurator
//   busy                high whenever a reconfiguration is in progress
//   done                1-cycle pulse, request completed (switch or no-op)
//   err_id              1-cycle pulse, illegal ID requested and dropped
//   inflight            tokens accepted at the input and not yet delivered
//   err_timeout         (macro only) 1-cycle pulse, drain aborted
// -----------------------------------------------------------------------------
module reconf_ctrl #(
  parameter int ID_W           = 8,
  parameter int NUM_CFG        = 3,
  parameter int RESET_ID       = 1,
  parameter int CNT_W          = 8,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [ID_W-1:0]  req_id,
  output logic             req_ready,
  input  logic             dp_in_valid,
  input  logic             dp_in_ready,
  input  logic             dp_out_valid,
  input  logic             dp_out_ready,
  output logic             in_en,
  output logic [ID_W-1:0]  cfg_id,
  output logic             busy,
  output logic             done,
  output logic             err_id,
  output logic [CNT_W-1:0] inflight
`ifdef RECONF_DRAIN_TIMEOUT_EN
  ,
  output logic             err_timeout
`endif
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_SWITCH,
    ST_SETTLE
  } state_t;

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [ID_W-1:0]  ID_MAX      = ID_W'(NUM_CFG);
  localparam logic [ID_W-1:0]  ID_RST      = ID_W'(RESET_ID);

  // Elaboration-time parameter sanity checks.
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 1");
  end
  if (RESET_ID < 1 || RESET_ID > NUM_CFG) begin : g_bad_reset_id
    $error("RESET_ID must be a legal network ID");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  state_t           state, state_next;
  logic [ID_W-1:0]  pending;
  logic [SET_W-1:0] settle_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             in_fire, out_fire, req_fire, id_legal;
  logic             pending_load, cfg_load, done_next, err_id_next;

`ifdef RECONF_DRAIN_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] drain_timer;
  logic            timeout_next;
`endif

  assign in_fire   = dp_in_valid & dp_in_ready;
  assign out_fire  = dp_out_valid & dp_out_ready;
  assign req_ready = (state == ST_RUN);
  assign req_fire  = req_valid & req_ready;
  assign id_legal  = (req_id != '0) && (req_id <= ID_MAX);
  assign busy      = (state != ST_RUN);

  // In-flight counter: saturates at both ends. The top never lets an in_fire
  // through at the maximum because in_en is low there.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    cnt_next = inflight;
    if (in_fire && !out_fire && inflight != CNT_MAX) begin
      cnt_next = inflight + CNT_W'(1);
    end else if (out_fire && !in_fire && inflight != '0) begin
      cnt_next = inflight - CNT_W'(1);
    end
  end

  always_comb begin
    state_next   = state;
    pending_load = 1'b0;
    cfg_load     = 1'b0;
    done_next    = 1'b0;
    err_id_next  = 1'b0;
`ifdef RECONF_DRAIN_TIMEOUT_EN
    timeout_next = 1'b0;
`endif
    case (state)
      ST_RUN: begin
        if (req_fire) begin
          if (!id_legal) begin
            err_id_next = 1'b1;
          end else if (req_id == cfg_id) begin
            done_next = 1'b1;
          end else begin
            pending_load = 1'b1;
            state_next   = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // An empty datapath always wins over a coincident timeout.
        if (inflight == '0) begin
          state_next = ST_SWITCH;
`ifdef RECONF_DRAIN_TIMEOUT_EN
        end else if (drain_timer == TO_LAST) begin
          state_next   = ST_RUN;
          timeout_next = 1'b1;
`endif
        end
      end
      ST_SWITCH: begin
        cfg_load   = 1'b1;
        state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_next = ST_RUN;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      pending    <= '0;
      cfg_id     <= ID_RST;
      inflight   <= '0;
      in_en      <= 1'b1;
      settle_cnt <= '0;
      done       <= 1'b0;
      err_id     <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= cnt_next;
      // Registered enable is computed from next-cycle values so it tracks
      // the state and counter it qualifies without a cycle of lag.
      in_en    <= (state_next == ST_RUN) && (cnt_next != CNT_MAX);
      done     <= done_next;
      err_id   <= err_id_next;
      if (pending_load) pending <= req_id;
      if (cfg_load)     cfg_id  <= pending;
      // Counts SETTLE cycles and sits at zero everywhere else.
      settle_cnt <= (state == ST_SETTLE) ? settle_cnt + SET_W'(1) : '0;
    end
  end

`ifdef RECONF_DRAIN_TIMEOUT_EN
  // Timer is zero outside DRAIN, so it is cleared on every entry to DRAIN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drain_timer <= '0;
      err_timeout <= 1'b0;
    end else begin
      drain_timer <= (state == ST_DRAIN) ? drain_timer + TO_W'(1) : '0;
      err_timeout <= timeout_next;
    end
  end
`endif

endmodule

// File: tb/tb_reconf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reconf_ctrl
//   Self-checking bench for reconf_ctrl (default build). A schedule-based model
//   tracks the configured ID and the token count. Once a switch is accepted,
//   the model records the first cycle at which the datapath is seen empty.
//   The ID change and the completion are then placed at fixed offsets from that
//   cycle. All DUT outputs are compared against the model at every negedge.
//   Directed sections pin the model with literal expectations. A randomized
//   section follows them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reconf_ctrl;

  localparam int ID_W    = 8;
  localparam int CNT_W   = 8;
  localparam int NUM_CFG = 3;
  localparam int S       = 2;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             req_valid;
  logic [ID_W-1:0]  req_id;
  logic             req_ready;
  logic             dp_in_valid, dp_in_ready, dp_out_valid, dp_out_ready;
  logic             in_en;
  logic [ID_W-1:0]  cfg_id;
  logic             busy, done, err_id;
  logic [CNT_W-1:0] inflight;

  reconf_ctrl #(
    .ID_W(ID_W), .NUM_CFG(NUM_CFG), .RESET_ID(1), .CNT_W(CNT_W),
    .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_id(req_id), .req_ready(req_ready),
    .dp_in_valid(dp_in_valid), .dp_in_ready(dp_in_ready),
    .dp_out_valid(dp_out_valid), .dp_out_ready(dp_out_ready),
    .in_en(in_en), .cfg_id(cfg_id), .busy(busy), .done(done),
    .err_id(err_id), .inflight(inflight)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model
  int cyc;
  int m_cfg, m_cnt, m_pending, m_drained_at;
  bit m_busy, m_done, m_err;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit model_in_en();
    return !m_busy && (m_cnt != CMAX);
  endfunction

  task automatic model_reset();
    m_cfg = 1; m_cnt = 0; m_pending = 0; m_drained_at = -1;
    m_busy = 0; m_done = 0; m_err = 0;
  endtask

  // Advance the model across one clock edge, given what fired in the cycle.
  task automatic model_step(input bit rv, input int rid, input bit inf, input bit outf);
    bit was_busy;
    int c0;
    was_busy = m_busy;
    c0 = m_cnt;
    if (inf && !outf && m_cnt < CMAX) m_cnt++;
    else if (outf && !inf && m_cnt > 0) m_cnt--;
    m_done = 0;
    m_err  = 0;
    if (!was_busy) begin
      if (rv) begin
        if (rid < 1 || rid > NUM_CFG) m_err = 1;
        else if (rid == m_cfg) m_done = 1;
        else begin
          m_busy = 1; m_pending = rid; m_drained_at = -1;
        end
      end
    end else begin
      if (m_drained_at < 0 && c0 == 0) m_drained_at = cyc;
      if (m_drained_at >= 0 && cyc == m_drained_at + 1) m_cfg = m_pending;
      if (m_drained_at >= 0 && cyc == m_drained_at + 1 + S) begin
        m_busy = 0; m_done = 1;
      end
    end
    cyc++;
  endtask

  task automatic compare_all();
    check("inflight",  inflight,  m_cnt);
    check("busy",      busy,      m_busy);
    check("req_ready", req_ready, !m_busy);
    check("in_en",     in_en,     model_in_en());
    check("cfg_id",    cfg_id,    m_cfg);
    check("done",      done,      m_done);
    check("err_id",    err_id,    m_err);
  endtask

  // One clock cycle: drive at negedge, update the model at posedge, then
  // compare at the following negedge. Input valid is gated by the expected in_en.
  task automatic cycle(input bit rv, input int rid, input bit iv, input bit ir,
                       input bit ov, input bit orr);
    bit inf, outf;
    req_valid    = rv;
    req_id       = rid[ID_W-1:0];
    dp_in_valid  = iv && model_in_en();
    dp_in_ready  = ir;
    dp_out_valid = ov;
    dp_out_ready = orr;
    inf  = dp_in_valid && ir;
    outf = ov && orr;
    @(posedge clock);
    model_step(rv, rid, inf, outf);
    @(negedge clock);
    compare_all();
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int rid;
    int guard;
    reset = 1'b1;
    req_valid = 0; req_id = '0;
    dp_in_valid = 0; dp_in_ready = 0; dp_out_valid = 0; dp_out_ready = 0;
    cyc = 0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    compare_all();
    check("rst_cfg_id",    cfg_id,    1);
    check("rst_in_en",     in_en,     1);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy",      busy,      0);
    check("rst_inflight",  inflight,  0);

    // Idle switch to ID 2 (request accepted at cycle T).
    cycle(1, 2, 0, 0, 0, 0);
    check("sw2_in_en_t1", in_en, 0);
    check("sw2_busy_t1",  busy,  1);
    idle();
    check("sw2_cfg_t2", cfg_id, 1);
    idle();
    check("sw2_cfg_t3", cfg_id, 2);
    idle();
    check("sw2_done_t4", done, 0);
    idle();
    check("sw2_done_t5",  done,  1);
    check("sw2_in_en_t5", in_en, 1);
    check("sw2_busy_t5",  busy,  0);

    // Same ID: immediate done, never busy.
    cycle(1, 2, 0, 0, 0, 0);
    check("same_done", done, 1);
    check("same_busy", busy, 0);
    idle();
    check("same_done_clr", done, 0);

    // Illegal IDs 0 and 4.
    cycle(1, 0, 0, 0, 0, 0);
    check("ill0_err", err_id, 1);
    check("ill0_cfg", cfg_id, 2);
    cycle(1, 4, 0, 0, 0, 0);
    check("ill4_err",  err_id, 1);
    check("ill4_busy", busy,   0);
    idle();
    check("ill_err_clr", err_id, 0);

    // Three tokens in flight; the third in_fire coincides with the request.
    cycle(0, 0, 1, 1, 0, 0);
    cycle(0, 0, 1, 1, 0, 0);
    cycle(1, 3, 1, 1, 0, 0);
    check("tok_inflight", inflight, 3);
    check("tok_in_en",    in_en,    0);
    repeat (6) cycle(0, 0, 1, 1, 0, 0);
    check("tok_hold_cnt", inflight, 3);
    check("tok_hold_cfg", cfg_id,   2);
    check("tok_hold_bsy", busy,     1);
    repeat (3) cycle(0, 0, 0, 0, 1, 1);
    check("tok_empty",    inflight, 0);
    check("tok_cfg_x1",   cfg_id,   2);
    idle();
    check("tok_cfg_x2", cfg_id, 2);
    idle();
    check("tok_cfg_x3", cfg_id, 3);
    idle();
    idle();
    check("tok_done_x5", done, 1);

    // Counter boundaries: underflow and simultaneous fires.
    cycle(0, 0, 0, 0, 1, 1);
    check("underflow", inflight, 0);
    cycle(0, 0, 1, 1, 1, 1);
    check("both_at_0", inflight, 0);
    cycle(0, 0, 1, 1, 0, 0);
    cycle(0, 0, 1, 1, 1, 1);
    check("both_at_1", inflight, 1);

    // Saturation: in_en closes at the counter maximum.
    repeat (CMAX + 5) cycle(0, 0, 1, 1, 0, 0);
    check("sat_cnt",   inflight, CMAX);
    check("sat_in_en", in_en,    0);
    cycle(0, 0, 1, 1, 1, 1);
    check("sat_dec",   inflight, CMAX - 1);
    check("sat_reopen", in_en,   1);
    guard = 0;
    while (m_cnt != 0 && guard < 600) begin
      cycle(0, 0, 0, 0, 1, 1);
      guard++;
    end
    check("sat_drained", inflight, 0);

    // Randomized traffic and requests.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 5),
            $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1));
    end

    // Quiesce: drain tokens and let any reconfiguration finish.
    guard = 0;
    while ((m_busy || m_cnt != 0) && guard < 600) begin
      cycle(0, 0, 0, 0, 1, 1);
      guard++;
    end
    check("quiesce_busy", busy,     0);
    check("quiesce_cnt",  inflight, 0);

    // Reset asserted while in SETTLE.
    rid = (m_cfg == 2) ? 3 : 2;
    cycle(1, rid, 0, 0, 0, 0);
    idle();
    idle();
    check("settle_cfg",  cfg_id, rid);
    check("settle_busy", busy,   1);
    reset = 1'b1;
    #1;
    check("rs_cfg_id",    cfg_id,    1);
    check("rs_busy",      busy,      0);
    check("rs_in_en",     in_en,     1);
    check("rs_req_ready", req_ready, 1);
    check("rs_done",      done,      0);
    model_reset();
    @(posedge clock);
    model_step(0, 0, 0, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    compare_all();
    for (int i = 0; i < 200; i++) begin
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 4),
            $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
